rst_seq_ctrl: RTL and testbench
===============================

Name: rst_seq_ctrl

Overview:
Reset sequencer that sits directly after the clock/reset block. It takes the debounced, PLL-qualified system reset and releases a set of downstream reset domains in a fixed order (domain 0 first), with a programmable gap between releases. It also accepts reset requests from on-chip sources such as the soft-reset CSR, the watchdog and debug. On a request it reasserts every domain and re-runs the sequence.

Parameters:
NUM_DOMAINS_p, 3, number of sequenced reset domains; must be >=1; domain 0 is released first.
NUM_REQ_p, 3, number of reset-request inputs; must be >=1.
ASSERT_HOLD_p, 16, minimum cycles all domains stay asserted after the hold (re)starts; must be >=1.
STAGE_DELAY_p, 8, cycles between consecutive domain releases; must be >=1.

Ports:
i_clk  input  1  system clock (the clock output of the clock/reset block)
i_rst_n  input  1  synchronous, active-low reset (the reset output of the clock/reset block)
i_req  input  NUM_REQ_p  level reset requests; any bit high requests a full reset
o_rst_n  output  NUM_DOMAINS_p  active-low reset per domain, registered
o_busy  output  1  high while any domain is held or not yet released
o_done  output  1  one-cycle pulse when the last domain is released
o_cause  output  NUM_REQ_p+1  reset cause; only meaningful with the optional feature

Behaviour:
- One clock; all flops are synchronous to i_clk. Reset is synchronous and active-low.
- i_rst_n low at any edge, in any state:
  - next state is RESET;
  - o_rst_n = all 0, o_busy = 1, o_done = 0;
  - counters cleared, i_req ignored.
- States:
  - RESET: left at the first edge with i_rst_n=1; this edge is E0 and the next state is HOLD with cnt=0.
  - HOLD: all o_rst_n=0.
    - Any edge with i_req!=0 reloads cnt to 0 and redefines E0 as that edge.
    - Otherwise cnt increments.
    - o_rst_n[0] rises after edge E0+ASSERT_HOLD_p; the state becomes RELEASE with k=0.
  - RELEASE: after edge E0+ASSERT_HOLD_p+k*STAGE_DELAY_p, o_rst_n[k] rises.
    - Released domains stay high.
    - When k=NUM_DOMAINS_p-1 is released, the state becomes RUN.
    - o_done is high in the same cycle o_rst_n[NUM_DOMAINS_p-1] first reads 1.
    - o_busy falls in that same cycle.
  - RUN: all o_rst_n=1, o_busy=0.
    - An edge Er with i_req!=0 drives all o_rst_n to 0 after Er.
    - The state becomes HOLD, with E0=Er.
- Request during RELEASE: same as in RUN. All domains, including already released ones, reassert at the next edge and the sequence restarts from HOLD.
- Simultaneous requests: OR-reduced, with no priority.
- Request held high: hold is extended indefinitely. Counting begins after the last edge with i_req!=0.
- NUM_DOMAINS_p=1: RELEASE collapses to one step, and o_done coincides with the o_rst_n[0] rise.
- Counter width is $clog2(max(ASSERT_HOLD_p,STAGE_DELAY_p)+1). The counter must not wrap; it saturates or reloads exactly at terminal count.
- All outputs are registered, with no combinational path from inputs to outputs.

Optional Feature:
Macro RST_SEQ_CAUSE_EN.
- Defined: o_cause is a register.
  - Bit 0 = system reset; bit r+1 = i_req[r].
  - Reset value is 1 (bit 0 only).
  - At the edge a request triggers the assertion from RUN or RELEASE, o_cause loads {i_req,1'b0}, overwriting the previous value.
  - In HOLD, further request bits are ORed in.
  - Holds its value in RELEASE and RUN.
- Not defined: o_cause is tied to 0; no flops are generated.

Test Plan:
All scenarios use NUM_DOMAINS_p=3, NUM_REQ_p=3, ASSERT_HOLD_p=4, STAGE_DELAY_p=3.
- Power-up: i_rst_n low for 5 cycles, then high (E0) -> o_rst_n rises bit by bit at E0+4, E0+7, E0+10; o_done high one cycle after E0+10; o_busy=1 until then, then 0.
- Request in RUN: i_req=3'b010 for 1 cycle at edge Er -> o_rst_n=3'b000 after Er; release at Er+4, Er+7, Er+10; o_cause=4'b0100 if RST_SEQ_CAUSE_EN.
- Held request: i_req[0] high for 20 cycles, last high at edge El -> o_rst_n stays 0 throughout; o_rst_n[0] rises after El+4.
- Request mid-RELEASE: i_req=3'b100 one edge after o_rst_n[0] rises -> all three domains 0 next cycle; full sequence restarts; one o_done pulse at the end only.
- Reset mid-sequence: i_rst_n low during RELEASE with o_rst_n=3'b011 -> all outputs at reset values after that edge; o_cause=4'b0001 with the macro; the sequence restarts from the E0 timing.
- Simultaneous requests: i_req=3'b101 at one edge in RUN -> o_cause=4'b1010 with the macro; without the macro o_cause=0 in every scenario.

Source files
------------

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: reset sequencer placed after the clock/reset block.
// Holds all downstream reset domains asserted for ASSERT_HOLD_p cycles, then
// releases them one at a time (domain 0 first) every STAGE_DELAY_p cycles.
// Any on-chip reset request reasserts every domain and restarts the sequence.
//
// Ports:
//   i_clk    system clock
//   i_rst_n  synchronous active-low reset
//   i_req    level reset requests, OR-reduced
//   o_rst_n  registered active-low reset per domain
//   o_busy   high while any domain is held or not yet released
//   o_done   one-cycle pulse when the last domain is released
//   o_cause  reset cause register (bit 0 = system reset, bit r+1 = i_req[r])
//
// Optional feature macro: RST_SEQ_CAUSE_EN (enables the o_cause register;
// otherwise o_cause is tied to zero).
module rst_seq_ctrl #(
  parameter int unsigned NUM_DOMAINS_p = 3,
  parameter int unsigned NUM_REQ_p     = 3,
  parameter int unsigned ASSERT_HOLD_p = 16,
  parameter int unsigned STAGE_DELAY_p = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NUM_REQ_p-1:0]   i_req,
  output logic [NUM_DOMAINS_p-1:0] o_rst_n,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [NUM_REQ_p:0]     o_cause
);

  localparam int unsigned MAX_DLY = (ASSERT_HOLD_p > STAGE_DELAY_p) ? ASSERT_HOLD_p : STAGE_DELAY_p;
  localparam int unsigned CW      = $clog2(MAX_DLY + 1);
  localparam int unsigned KW      = $clog2(NUM_DOMAINS_p + 1);

  localparam logic [CW-1:0] HOLD_TC  = CW'(ASSERT_HOLD_p - 1);
  localparam logic [CW-1:0] STAGE_TC = CW'(STAGE_DELAY_p - 1);
  localparam logic [KW-1:0] LAST_K   = KW'(NUM_DOMAINS_p - 1);
  localparam logic [NUM_DOMAINS_p-1:0] DOM0 = NUM_DOMAINS_p'(1);

  typedef enum logic [1:0] {
    ST_RESET,
    ST_HOLD,
    ST_RELEASE,
    ST_RUN
  } state_e;

  state_e                   state_q;
  logic [CW-1:0]            cnt_q;
  logic [KW-1:0]            k_q;
  logic [NUM_DOMAINS_p-1:0] rst_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     req_any_d;

  assign req_any_d = |i_req;

  // cnt_q holds (edges since the last (re)start) - 1 and reloads to 0 exactly
  // at each terminal count, so it never wraps.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_RESET;
      cnt_q   <= '0;
      k_q     <= '0;
      rst_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_RESET: begin
          state_q <= ST_HOLD;
          cnt_q   <= '0;
        end
        ST_HOLD: begin
          if (req_any_d) begin
            cnt_q <= '0;
          end else if (cnt_q == HOLD_TC) begin
            cnt_q <= '0;
            rst_q <= DOM0;
            if (NUM_DOMAINS_p == 1) begin
              state_q <= ST_RUN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_RELEASE;
              k_q     <= KW'(1);
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_RELEASE: begin
          if (req_any_d) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            k_q     <= '0;
            rst_q   <= '0;
          end else if (cnt_q == STAGE_TC) begin
            cnt_q <= '0;
            rst_q <= rst_q | (DOM0 << k_q);
            if (k_q == LAST_K) begin
              state_q <= ST_RUN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              k_q <= k_q + KW'(1);
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_RUN: begin
          if (req_any_d) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            k_q     <= '0;
            rst_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        default: state_q <= ST_RESET;
      endcase
    end
  end

  assign o_rst_n = rst_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;

`ifdef RST_SEQ_CAUSE_EN
  logic [NUM_REQ_p:0] cause_q;

  // A request that starts a new assertion replaces the cause; requests
  // arriving while already held accumulate.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cause_q <= (NUM_REQ_p + 1)'(1);
    end else if (req_any_d) begin
      unique case (state_q)
        ST_RELEASE, ST_RUN: cause_q <= {i_req, 1'b0};
        ST_HOLD:            cause_q <= cause_q | {i_req, 1'b0};
        default:            cause_q <= cause_q;
      endcase
    end
  end

  assign o_cause = cause_q;
`else
  assign o_cause = '0;
`endif

endmodule

// File: tb/tb_rst_seq_ctrl.sv
module tb_rst_seq_ctrl;
  localparam int ND = 3;
  localparam int NR = 3;
  localparam int H  = 4;
  localparam int S  = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] req;
  logic [ND-1:0] o_rst_n;
  logic          o_busy;
  logic          o_done;
  logic [NR:0]   o_cause;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  rst_seq_ctrl #(
    .NUM_DOMAINS_p(ND),
    .NUM_REQ_p(NR),
    .ASSERT_HOLD_p(H),
    .STAGE_DELAY_p(S)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_req(req),
    .o_rst_n(o_rst_n),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_cause(o_cause)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Timing model: everything follows from the number of edges j since the
  // most recent sequence start E0.
  bit          valid = 0;
  bit          in_rst = 1;
  int          j = 0;
  logic [NR:0] mcause = 1;

  always @(posedge clk) begin
    valid = 1;
    if (!rst_n) begin
      in_rst = 1; j = 0; mcause = 1;
    end else if (in_rst) begin
      in_rst = 0; j = 0;
    end else if (req != 0) begin
      if (j < H) mcause = mcause | {req, 1'b0};
      else       mcause = {req, 1'b0};
      j = 0;
    end else if (j < 1000) begin
      j++;
    end
  end

  function automatic int released();
    int n;
    if (in_rst || j < H) return 0;
    n = 1 + (j - H) / S;
    return (n > ND) ? ND : n;
  endfunction

  always @(negedge clk) begin
    if (valid) begin
      int n;
      logic [ND-1:0] erst;
      logic [NR:0] ecause;
      n = released();
      erst = ND'((1 << n) - 1);
`ifdef RST_SEQ_CAUSE_EN
      ecause = mcause;
`else
      ecause = '0;
`endif
      chk("m_rst", 32'(o_rst_n), 32'(erst));
      chk("m_busy", 32'(o_busy), 32'(n < ND));
      chk("m_done", 32'(o_done), 32'(!in_rst && j == H + (ND - 1) * S));
      chk("m_cause", 32'(o_cause), 32'(ecause));
      if (o_done === 1'b1) done_cnt++;
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  function automatic logic [NR:0] cz(input logic [NR:0] v);
`ifdef RST_SEQ_CAUSE_EN
    return v;
`else
    return '0;
`endif
  endfunction

  initial begin
    int d0;
    bit found;
    rst_n = 1'b0;
    req   = '0;
    // Power-up
    repeat (5) cyc();
    chk("pu_rst_val", 32'(o_rst_n), 32'h0);
    chk("pu_busy_val", 32'(o_busy), 32'h1);
    chk("pu_cause_val", 32'(o_cause), 32'(cz(4'b0001)));
    rst_n = 1'b1;
    repeat (4) cyc();
    chk("pu_hold", 32'(o_rst_n), 32'h0);
    cyc();
    chk("pu_d0", 32'(o_rst_n), 32'h1);
    repeat (3) cyc();
    chk("pu_d1", 32'(o_rst_n), 32'h3);
    repeat (3) cyc();
    chk("pu_d2", 32'(o_rst_n), 32'h7);
    chk("pu_done", 32'(o_done), 32'h1);
    chk("pu_busy", 32'(o_busy), 32'h0);
    cyc();
    chk("pu_done_pulse", 32'(o_done), 32'h0);

    // Request in RUN
    req = 3'b010;
    cyc();
    req = '0;
    chk("rr_assert", 32'(o_rst_n), 32'h0);
    chk("rr_cause", 32'(o_cause), 32'(cz(4'b0100)));
    repeat (4) cyc();
    chk("rr_d0", 32'(o_rst_n), 32'h1);
    repeat (6) cyc();
    chk("rr_d2", 32'(o_rst_n), 32'h7);

    // Held request
    cyc();
    req = 3'b001;
    repeat (20) cyc();
    req = '0;
    chk("hr_held", 32'(o_rst_n), 32'h0);
    repeat (3) cyc();
    chk("hr_hold", 32'(o_rst_n), 32'h0);
    cyc();
    chk("hr_d0", 32'(o_rst_n), 32'h1);
    repeat (6) cyc();
    chk("hr_d2", 32'(o_rst_n), 32'h7);

    // Request mid-RELEASE
    req = 3'b100;
    cyc();
    req = '0;
    repeat (4) cyc();
    chk("mr_d0", 32'(o_rst_n), 32'h1);
    d0 = done_cnt;
    req = 3'b100;
    cyc();
    req = '0;
    chk("mr_all", 32'(o_rst_n), 32'h0);
    chk("mr_cause", 32'(o_cause), 32'(cz(4'b1000)));
    repeat (10) cyc();
    chk("mr_d2", 32'(o_rst_n), 32'h7);
    cyc();
    chk("mr_one_done", 32'(done_cnt - d0), 32'h1);

    // Reset mid-sequence
    req = 3'b001;
    cyc();
    req = '0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc();
      if (o_rst_n === 3'b011) found = 1;
    end
    chk("rm_reach_011", 32'(found), 32'h1);
    rst_n = 1'b0;
    cyc();
    chk("rm_rst", 32'(o_rst_n), 32'h0);
    chk("rm_busy", 32'(o_busy), 32'h1);
    chk("rm_done", 32'(o_done), 32'h0);
    chk("rm_cause", 32'(o_cause), 32'(cz(4'b0001)));
    rst_n = 1'b1;
    repeat (5) cyc();
    chk("rm_d0", 32'(o_rst_n), 32'h1);
    repeat (6) cyc();
    chk("rm_d2", 32'(o_rst_n), 32'h7);

    // Simultaneous requests
    cyc();
    req = 3'b101;
    cyc();
    req = '0;
    chk("sr_rst", 32'(o_rst_n), 32'h0);
    chk("sr_cause", 32'(o_cause), 32'(cz(4'b1010)));
    repeat (10) cyc();
    chk("sr_d2", 32'(o_rst_n), 32'h7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
